uart_rx: RTL and testbench

//  Serial receiver; the far end of the tx serializer. Recovers frames of

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Host-side bundle for uart_rx: serial line and frame format in, recovered
// byte and per-frame status pulses out.
interface uart_rx_if;
   logic       DATA_IN_Rx;
   logic       UART_BITS;
   logic       UART_PARITY;
   logic [7:0] DATA_OUT_Rx;
   logic       IRQ_Rx;
   logic       FRAME_ERR;
   logic       PARITY_ERR;

   modport master (
      output DATA_IN_Rx, UART_BITS, UART_PARITY,
      input  DATA_OUT_Rx, IRQ_Rx, FRAME_ERR, PARITY_ERR
   );

   modport slave (
      input  DATA_IN_Rx, UART_BITS, UART_PARITY,
      output DATA_OUT_Rx, IRQ_Rx, FRAME_ERR, PARITY_ERR
   );
endinterface

// File: rtl/uart_rx.sv
// Serial receiver: start, 7/8 data bits LSB first, optional parity slot, stop.
// Define UART_RX_PARITY_CHECK_EN to check even parity; otherwise the slot is discarded.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic     clk,
   input  logic     RST,
   uart_rx_if.slave bus
);

   localparam int unsigned MidOff = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned TickW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TickW-1:0] TickBit   = TickW'(CLKS_PER_BIT - 1);
   localparam logic [TickW-1:0] TickStart = (MidOff > 0) ? TickW'(MidOff - 1) : '0;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [TickW-1:0]       tick_q;
   logic [2:0]             bit_cnt_q;
   logic [7:0]             shift_q;
   logic                   eight_q;
   logic                   par_en_q;
   logic [7:0]             data_q;
   logic                   irq_q;
   logic                   ferr_q;
   logic                   rx_s;
   logic [2:0]             last_bit;

   assign rx_s     = sync_q[SYNC_STAGES-1];
   assign last_bit = eight_q ? 3'd7 : 3'd6;

`ifdef UART_RX_PARITY_CHECK_EN
   logic rx_par_q;
   logic perr_q;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         rx_par_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         perr_q <= 1'b0;
         if (state_q == StParity && tick_q == '0) rx_par_q <= rx_s;
         // Error rides alongside the good-frame IRQ; byte is still accepted.
         if (state_q == StStop && tick_q == '0 && rx_s && par_en_q) begin
            perr_q <= rx_par_q != (^shift_q);
         end
      end
   end

   assign bus.PARITY_ERR = perr_q;
`else
   assign bus.PARITY_ERR = 1'b0;
`endif

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         sync_q    <= '1;
         tick_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         eight_q   <= 1'b0;
         par_en_q  <= 1'b0;
         data_q    <= '0;
         irq_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.DATA_IN_Rx};
         irq_q  <= 1'b0;
         ferr_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  eight_q   <= bus.UART_BITS;
                  par_en_q  <= bus.UART_PARITY;
                  shift_q   <= '0;
                  bit_cnt_q <= '0;
                  // With a zero mid-bit offset the detecting cycle is the start sample.
                  if (MidOff == 0) begin
                     state_q <= StData;
                     tick_q  <= TickBit;
                  end else begin
                     state_q <= StStart;
                     tick_q  <= TickStart;
                  end
               end
            end
            StStart: begin
               if (tick_q != '0) begin
                  tick_q <= tick_q - 1'b1;
               end else if (rx_s) begin
                  state_q <= StIdle;
               end else begin
                  state_q <= StData;
                  tick_q  <= TickBit;
               end
            end
            StData: begin
               if (tick_q != '0) begin
                  tick_q <= tick_q - 1'b1;
               end else begin
                  shift_q[bit_cnt_q] <= rx_s;
                  tick_q             <= TickBit;
                  if (bit_cnt_q == last_bit) begin
                     state_q <= par_en_q ? StParity : StStop;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            StParity: begin
               if (tick_q != '0) begin
                  tick_q <= tick_q - 1'b1;
               end else begin
                  state_q <= StStop;
                  tick_q  <= TickBit;
               end
            end
            StStop: begin
               if (tick_q != '0) begin
                  tick_q <= tick_q - 1'b1;
               end else if (rx_s) begin
                  data_q  <= shift_q;
                  irq_q   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  ferr_q  <= 1'b1;
                  state_q <= StBreak;
               end
            end
            StBreak: begin
               // Hold off until the line idles so a stuck-low line cannot retrigger.
               if (rx_s) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.DATA_OUT_Rx = data_q;
   assign bus.IRQ_Rx      = irq_q;
   assign bus.FRAME_ERR   = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clk/bit, one at 4 clks/bit.
module tb_uart_rx;

   logic clk;
   logic RST;

   uart_rx_if if1 ();
   uart_rx_if if4 ();

   uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (.clk(clk), .RST(RST), .bus(if1));
   uart_rx #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut4 (.clk(clk), .RST(RST), .bus(if4));

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int irq1_n = 0, ferr1_n = 0, perr1_n = 0, irq1_at = -1, perr1_at = -1;
   int irq4_n = 0, flag4_n = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (if1.IRQ_Rx) begin
         irq1_n  <= irq1_n + 1;
         irq1_at <= cyc;
      end
      if (if1.FRAME_ERR) ferr1_n <= ferr1_n + 1;
      if (if1.PARITY_ERR) begin
         perr1_n  <= perr1_n + 1;
         perr1_at <= cyc;
      end
      if (if4.IRQ_Rx) irq4_n <= irq4_n + 1;
      if (if4.FRAME_ERR || if4.PARITY_ERR) flag4_n <= flag4_n + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit sel4, input logic b);
      if (sel4) begin
         if4.DATA_IN_Rx = b;
         repeat (4) @(posedge clk);
      end else begin
         if1.DATA_IN_Rx = b;
         @(posedge clk);
      end
      #1;
   endtask

   task automatic send_frame(input bit sel4, input logic [7:0] d, input bit eight,
                             input bit par_en, input logic par_bit, input logic stop_bit);
      drive_bit(sel4, 1'b0);
      for (int i = 0; i < (eight ? 8 : 7); i++) drive_bit(sel4, d[i]);
      if (par_en) drive_bit(sel4, par_bit);
      drive_bit(sel4, stop_bit);
   endtask

   int s, b_irq, b_ferr, b_perr;
   logic exp_perr;

   initial begin
      RST = 1'b0;
      if1.DATA_IN_Rx = 1'b1;  if1.UART_BITS = 1'b1;  if1.UART_PARITY = 1'b0;
      if4.DATA_IN_Rx = 1'b1;  if4.UART_BITS = 1'b1;  if4.UART_PARITY = 1'b0;
      idle(3);
      check_eq("rst_data", if1.DATA_OUT_Rx, 8'h00);
      check_eq("rst_flags", {if1.IRQ_Rx, if1.FRAME_ERR, if1.PARITY_ERR}, 3'b000);
      RST = 1'b1;
      idle(3);

      // 8N1 0xA5; IRQ lands in the 13th cycle counting the falling one as first
      b_irq = irq1_n;  s = cyc;
      send_frame(0, 8'hA5, 1, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("a5_irq", irq1_n - b_irq, 1);
      check_eq("a5_data", if1.DATA_OUT_Rx, 8'hA5);
      check_eq("a5_lat", irq1_at - s, 12);
      check_eq("a5_ferr", ferr1_n, 0);

      // 7-bit frame 0x5A is one bit shorter
      if1.UART_BITS = 1'b0;
      b_irq = irq1_n;  s = cyc;
      send_frame(0, 8'h5A, 0, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("7b_irq", irq1_n - b_irq, 1);
      check_eq("7b_data", if1.DATA_OUT_Rx, 8'h5A);
      check_eq("7b_lat", irq1_at - s, 11);

      // UART_BITS flipped mid-frame must not affect the frame in flight
      b_irq = irq1_n;
      fork
         send_frame(0, 8'h2B, 0, 0, 1'b0, 1'b1);
         begin idle(4); if1.UART_BITS = 1'b1; end
      join
      idle(4);
      check_eq("cfg_hold_irq", irq1_n - b_irq, 1);
      check_eq("cfg_hold_data", if1.DATA_OUT_Rx, 8'h2B);

      // Parity slot: 0x01 has odd weight, so even parity wants slot=1
      if1.UART_PARITY = 1'b1;
      b_irq = irq1_n;  b_perr = perr1_n;  s = cyc;
      send_frame(0, 8'h01, 1, 1, 1'b1, 1'b1);
      idle(4);
      check_eq("par_ok_irq", irq1_n - b_irq, 1);
      check_eq("par_ok_perr", perr1_n - b_perr, 0);
      check_eq("par_lat", irq1_at - s, 13);
`ifdef UART_RX_PARITY_CHECK_EN
      exp_perr = 1'b1;
`else
      exp_perr = 1'b0;
`endif
      if1.DATA_IN_Rx = 1'b1;
      b_irq = irq1_n;  b_perr = perr1_n;
      send_frame(0, 8'h01, 1, 1, 1'b0, 1'b1);
      idle(4);
      check_eq("par_bad_irq", irq1_n - b_irq, 1);
      check_eq("par_bad_perr", perr1_n - b_perr, exp_perr);
      check_eq("par_bad_data", if1.DATA_OUT_Rx, 8'h01);
      if (exp_perr) check_eq("par_bad_align", perr1_at, irq1_at);
      if1.UART_PARITY = 1'b0;

      // Stop bit low, line held low: one FRAME_ERR, byte kept, no retrigger
      b_irq = irq1_n;  b_ferr = ferr1_n;
      send_frame(0, 8'h77, 1, 0, 1'b0, 1'b0);
      idle(20);
      check_eq("brk_ferr", ferr1_n - b_ferr, 1);
      check_eq("brk_irq", irq1_n - b_irq, 0);
      check_eq("brk_data", if1.DATA_OUT_Rx, 8'h01);
      if1.DATA_IN_Rx = 1'b1;
      idle(4);
      send_frame(0, 8'h42, 1, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("brk_recover_irq", irq1_n - b_irq, 1);
      check_eq("brk_recover_data", if1.DATA_OUT_Rx, 8'h42);
      check_eq("brk_recover_ferr", ferr1_n - b_ferr, 1);

      // 4 clks/bit: a glitch shorter than the start-sample offset is rejected
      if4.DATA_IN_Rx = 1'b0;
      idle(1);
      if4.DATA_IN_Rx = 1'b1;
      idle(60);
      check_eq("glitch_irq", irq4_n, 0);
      check_eq("glitch_flags", flag4_n, 0);
      send_frame(1, 8'h3C, 1, 0, 1'b0, 1'b1);
      idle(10);
      check_eq("c4_irq", irq4_n, 1);
      check_eq("c4_data", if4.DATA_OUT_Rx, 8'h3C);
      check_eq("c4_flags", flag4_n, 0);

      // Back-to-back frames with no idle gap
      b_irq = irq1_n;
      send_frame(0, 8'h11, 1, 0, 1'b0, 1'b1);
      send_frame(0, 8'h22, 1, 0, 1'b0, 1'b1);
      idle(4);
      check_eq("b2b_irq", irq1_n - b_irq, 2);
      check_eq("b2b_data", if1.DATA_OUT_Rx, 8'h22);

      // Reset mid-frame aborts it and clears outputs
      b_irq = irq1_n;
      fork
         send_frame(0, 8'h33, 1, 0, 1'b0, 1'b1);
         begin idle(5); RST = 1'b0; end
      join
      idle(3);
      check_eq("rst_mid_data", if1.DATA_OUT_Rx, 8'h00);
      check_eq("rst_mid_data4", if4.DATA_OUT_Rx, 8'h00);
      RST = 1'b1;
      idle(6);
      check_eq("rst_mid_irq", irq1_n - b_irq, 0);
      check_eq("rst_mid_flags", {if1.IRQ_Rx, if1.FRAME_ERR, if1.PARITY_ERR}, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
